// File: rtl/load_store_unit.sv
// Load/store unit: validates one request at a time, drives the byte-lane data
// memory for a single cycle and returns extended load data over valid/ready.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int MEM_BYTES      = 2048
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [31:0]               req_wdata,
    output logic [MEM_ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]                mem_write_enable,
    output logic [3:0]                mem_read_enable,
    output logic [31:0]               mem_write_data,
    input  logic [31:0]               mem_read_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_data,
    output logic [1:0]                resp_error
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_BYTES);

    state_t      state;
    state_t      next_state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        we_q;
    logic [1:0]  req_error;
    logic [3:0]  lane_mask;
    logic        accept;
    logic [31:0] lane_data;
    logic [31:0] load_result;

    // Illegal size code outranks range, which outranks alignment.
    always_comb begin
        req_error = 2'b00;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_funct3[2] && req_we))
            req_error = 2'b11;
        else if (req_addr >= ADDR_LIMIT)
            req_error = 2'b10;
        else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
            req_error = 2'b01;
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   lane_mask = 4'b0001 << req_addr[1:0];
            2'b01:   lane_mask = 4'b0011 << req_addr[1:0];
            default: lane_mask = 4'b1111;
        endcase
    end

    always_comb begin
        lane_data = mem_read_data >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_result = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_result = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_result = {24'h0, lane_data[7:0]};
            3'b101:  load_result = {16'h0, lane_data[15:0]};
            default: load_result = lane_data;
        endcase
    end

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (req_error != 2'b00) ? RESP : ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    // NOTE: strobes are registered on this reset, so asserting reset_n low
    // mid-access clears them at once and the in-flight store never lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_address      <= '0;
            mem_write_enable <= 4'b0000;
            mem_read_enable  <= 4'b0000;
            mem_write_data   <= 32'h0;
            resp_data        <= 32'h0;
            resp_error       <= 2'b00;
            funct3_q         <= 3'b000;
            offset_q         <= 2'b00;
            we_q             <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    resp_data  <= 32'h0;
                    resp_error <= req_error;
                    funct3_q   <= req_funct3;
                    offset_q   <= req_addr[1:0];
                    we_q       <= req_we;
                    if (req_error == 2'b00) begin
                        mem_address <= req_addr[MEM_ADDR_WIDTH-1:0];
                        if (req_we) begin
                            mem_write_enable <= lane_mask;
                            mem_write_data   <= req_wdata << {req_addr[1:0], 3'b000};
                        end else begin
                            mem_read_enable  <= lane_mask;
                        end
                    end
                end
                ACCESS: begin
                    mem_write_enable <= 4'b0000;
                    mem_read_enable  <= 4'b0000;
                    mem_write_data   <= 32'h0;
                    if (!we_q) resp_data <= load_result;
                end
                RESP: if (resp_ready) begin
                    resp_data  <= 32'h0;
                    resp_error <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the byte-lane data memory. Takes one load/store request at a time from the execute stage.
- Validates the request, then drives the memory's 11-bit address, per-lane write/read enables and lane-aligned write data for exactly one cycle.
- For loads, captures the memory's read word, extracts and sign/zero-extends the addressed byte, halfword or word, and returns it through a valid/ready response port.

Parameters:
- ADDR_WIDTH, 32, width of the request address.
- MEM_ADDR_WIDTH, 11, width of the memory address.
- MEM_BYTES, 2048, memory size in bytes; any request address >= MEM_BYTES is out of range.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned. The 1xx codes are loads only.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-justified.
- mem_address  output  MEM_ADDR_WIDTH  byte address to memory.
- mem_write_enable  output  4  per-lane write strobe.
- mem_read_enable  output  4  per-lane read strobe.
- mem_write_data  output  32  store data shifted into its lanes.
- mem_read_data  input  32  memory read word; valid at the posedge ending ACCESS.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_data  output  32  extended load result; 0 for stores and errors.
- resp_error  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

Behaviour:
Reset (asynchronous, active-low):
- While reset_n=0: state=IDLE; req_ready=1 (IDLE).
- Outputs reset to 0: resp_valid, resp_data, resp_error, mem_address, mem_write_enable, mem_read_enable, mem_write_data.

FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On posedge with req_valid=1, latch the request and compute the error.
  - error≠00: go to RESP with resp_error set, resp_data=0, memory strobes never asserted.
  - error=00: go to ACCESS and register the memory outputs.
- ACCESS (exactly one cycle):
  - mem_address = req_addr[MEM_ADDR_WIDTH-1:0].
  - Lane offset o = addr[1:0].
  - Lane mask: byte = 0001<<o; half = 0011<<o; word = 1111.
  - Store: mem_write_enable = mask; mem_write_data = wdata<<(8*o) (word: unshifted); mem_read_enable=0.
  - Load: mem_read_enable = mask; mem_write_enable=0.
  - At the posedge ending ACCESS, all strobes return to 0 and the state goes to RESP.
  - For loads, the same posedge captures mem_read_data>>(8*o), masked to size:
    - signed codes: sign-extended from bit 7 (byte) or bit 15 (half);
    - unsigned codes: zero-extended.
- RESP:
  - resp_valid=1; resp_data and resp_error are held stable while resp_ready=0.
  - On posedge with resp_ready=1: resp_valid drops to 0, state goes to IDLE, resp_data and resp_error clear to 0.
  - A new request is not accepted in that same edge.

Error checks, in priority order:
1. Illegal funct3 (011, 11x, or 1xx with req_we=1) → 11.
2. req_addr >= MEM_BYTES → 10.
3. Misalignment → 01: half with addr[0]=1; word with addr[1:0]≠00.

Timing:
- Accept at edge k.
- Strobes are high during cycle k+1.
- resp_valid is high from edge k+2.
- Minimum 3 cycles per request when resp_ready is tied high.
- Error responses: resp_valid is high from edge k+1.

Boundaries:
- Address MEM_BYTES-1 with byte size is legal; a word at MEM_BYTES-4 is legal.
- req_valid while not IDLE is ignored; the request stays pending upstream.
- Reset asserted during ACCESS clears the strobes immediately and asynchronously. The store is abandoned and no posedge write occurs from this block.
- Reset asserted during RESP drops the response.

Test Plan:
1. SW addr 0x010 data 0xDEADBEEF, then LW 0x010 → ACCESS: write_enable=1111, write_data=0xDEADBEEF. Load returns 0xDEADBEEF, error 00, resp_valid at k+2.
2. SB addr 0x013 data 0x000000A5 → write_enable=1000, write_data=0xA5000000. Then LB 0x013 → 0xFFFFFFA5 and LBU 0x013 → 0x000000A5.
3. SH addr 0x022 data 0x8001, then LH 0x022 → write_enable=1100. Load read_enable=1100, result 0xFFFF8001; LHU gives 0x00008001.
4. LW addr 0x006 → resp_error=01, resp_valid at k+1, no strobe ever asserted. LB addr 0x800 → error 10. Store with funct3=100 → error 11.
5. Load with resp_ready=0 for 5 cycles → resp_valid/resp_data stable, req_ready=0, second req_valid ignored. Release → accepted after return to IDLE.
6. Assert reset_n=0 mid-ACCESS of an SW → mem_write_enable drops to 0 before the next posedge and state=IDLE. A following LW of that address returns the prior memory contents.
